dm_mem_responder: RTL

//  Data-memory responder: the memory end of the M-stage store/load interface. It accepts one request at
//  a time (byte-enabled store or typed load), commits stores lane-by-lane, and returns a response after a

---
 rtl/dm_mem_responder_pkg.sv | 58 +++++
 rtl/dm_mem_responder_load_ext.sv | 40 ++++
 rtl/dm_mem_responder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dm_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: load-type codes,
// FSM state encoding, store byte-enable patterns and the alignment rule
// used when DM_ALIGN_CHECK_EN is defined.
package dm_mem_responder_pkg;

  // Load type codes; any other code is treated as a full-word load.
  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_HU = 3'd2;
  localparam logic [2:0] LD_B  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;

  // Byte-enable patterns shared with the store byte-enable generator.
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_B0      = 4'b0001;
  localparam logic [3:0] BE_B1      = 4'b0010;
  localparam logic [3:0] BE_B2      = 4'b0100;
  localparam logic [3:0] BE_B3      = 4'b1000;

  // Request/response FSM: IDLE -> WAIT -> RESP -> IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // True when the access does not match its natural alignment.
  // Loads are judged by ldtype, stores by their byte-enable pattern.
  function automatic logic is_misaligned(input logic [1:0] lo,
                                         input logic [3:0] be,
                                         input logic [2:0] ldt);
    logic m;
    m = 1'b0;
    if (be == BE_NONE) begin
      case (ldt)
        LD_H, LD_HU: m = lo[0];
        LD_B, LD_BU: m = 1'b0;
        default:     m = (lo != 2'b00);
      endcase
    end else begin
      case (be)
        BE_WORD:    m = (lo != 2'b00);
        BE_HALF_LO: m = (lo != 2'b00);
        BE_HALF_HI: m = (lo != 2'b10);
        BE_B0:      m = (lo != 2'b00);
        BE_B1:      m = (lo != 2'b01);
        BE_B2:      m = (lo != 2'b10);
        BE_B3:      m = (lo != 2'b11);
        default:    m = 1'b1;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/dm_mem_responder_load_ext.sv
// Load extractor: picks the addressed byte/halfword out of a 32-bit word
// and sign- or zero-extends it according to the load type.
module dm_load_ext
  import dm_mem_responder_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lo,
  input  logic [2:0]  i_ldtype,
  output logic [31:0] o_data
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  assign w_half = i_lo[1] ? i_word[31:16] : i_word[15:0];

  // Byte lane select by the low two address bits.
  always_comb begin
    w_byte = i_word[7:0];
    case (i_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
  end

  // Extension by load type; unknown codes return the whole word.
  always_comb begin
    o_data = i_word;
    case (i_ldtype)
      LD_H:    o_data = {{16{w_half[15]}}, w_half};
      LD_HU:   o_data = {16'h0000, w_half};
      LD_B:    o_data = {{24{w_byte[7]}}, w_byte};
      LD_BU:   o_data = {24'h000000, w_byte};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/dm_mem_responder.sv
// Data-memory responder: accepts one store/load at a time, commits store
// lanes on the accept edge, and answers after LATENCY cycles.
// Optional alignment checking is enabled with `define DM_ALIGN_CHECK_EN.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; a response transfers on a rising edge where
// rsp_valid and rsp_ready are both high. rsp_* hold steady until taken.
module dm_mem_responder
  import dm_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_byteen,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_ldtype,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t              r_state;
  state_t              w_next_state;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_idx;
  logic [1:0]          r_lo;
  logic [2:0]          r_ldtype;
  logic                r_is_load;
  logic                r_err;
  logic                r_rsp_valid;
  logic [31:0]         r_rsp_rdata;
  logic                r_rsp_err;
  logic [31:0]         r_mem [0:(1<<ADDR_W)-1];

  logic                w_accept;
  logic                w_misalign;
  logic                w_we;
  logic [ADDR_W-1:0]   w_idx;
  logic                w_enter_resp;
  logic [ADDR_W-1:0]   w_src_idx;
  logic [1:0]          w_src_lo;
  logic [2:0]          w_src_ldtype;
  logic                w_src_load;
  logic                w_src_err;
  logic [31:0]         w_ext;
  logic                w_unused_addr;

  assign w_unused_addr = ^req_addr[31:ADDR_W+2];
  assign w_idx         = req_addr[ADDR_W+1:2];
  assign w_accept      = req_valid && (r_state == ST_IDLE);

`ifdef DM_ALIGN_CHECK_EN
  assign w_misalign = is_misaligned(req_addr[1:0], req_byteen, req_ldtype);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_we      = w_accept && (req_byteen != BE_NONE) && !w_misalign;
  assign req_ready = (r_state == ST_IDLE);
  assign dbg_state = r_state;

  // With LATENCY==1 RESP is entered on the accept edge itself, so the
  // response is built from the live request rather than the latches.
  assign w_src_idx    = (r_state == ST_IDLE) ? w_idx : r_idx;
  assign w_src_lo     = (r_state == ST_IDLE) ? req_addr[1:0] : r_lo;
  assign w_src_ldtype = (r_state == ST_IDLE) ? req_ldtype : r_ldtype;
  assign w_src_load   = (r_state == ST_IDLE) ? (req_byteen == BE_NONE) : r_is_load;
  assign w_src_err    = (r_state == ST_IDLE) ? w_misalign : r_err;

  dm_load_ext u_load_ext (
    .i_word   (r_mem[w_src_idx]),
    .i_lo     (w_src_lo),
    .i_ldtype (w_src_ldtype),
    .o_data   (w_ext)
  );

  // Memory array: no reset, enabled lanes written on the accept edge.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (req_byteen[i]) r_mem[w_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_next_state = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd0) w_next_state = ST_RESP;
      ST_RESP: if (rsp_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_enter_resp = (w_next_state == ST_RESP) && (r_state != ST_RESP);

  // Latency counter and request latches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_lo      <= 2'd0;
      r_ldtype  <= LD_W;
      r_is_load <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= CNT_INIT;
      r_idx     <= w_idx;
      r_lo      <= req_addr[1:0];
      r_ldtype  <= req_ldtype;
      r_is_load <= (req_byteen == BE_NONE);
      r_err     <= w_misalign;
    end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Response registers: loaded on entry to RESP, cleared when taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= (w_src_load && !w_src_err) ? w_ext : 32'h0;
      r_rsp_err   <= w_src_err;
    end else if (r_state == ST_RESP && rsp_ready) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
`ifdef DM_ALIGN_CHECK_EN
  assign rsp_err   = r_rsp_err;
`else
  assign rsp_err   = 1'b0 & r_rsp_err;
`endif

endmodule
